// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory while holding the core in reset.
//   Bytes (in_valid/in_ready/in_data) are packed little-endian into 32-bit words and
//   written one word per WRITE cycle (imem_we/imem_addr/imem_wdata). start + len
//   begin a load; busy/done report progress; cpu_hold releases the core once a load
//   completes cleanly. reset is asynchronous, active low.
//   Optional macro IMEM_LOADER_CHECKSUM_EN: after the last word, four more bytes carry
//   the expected XOR of all words; error flags a mismatch and keeps cpu_hold high.
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK   = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_lo;

  logic [ADDR_W:0]   len_sat;
  logic [31:0]       full_word;
  logic              last_word;
  logic              xfer;

  always_comb begin
    len_sat   = (len > DEPTH_L) ? DEPTH_L : len;
    full_word = {in_data, asm_lo};
    last_word = (({1'b0, idx} + (ADDR_W+1)'(1)) >= len_q);
    xfer      = in_valid && in_ready;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] acc;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      byte_cnt   <= '0;
      asm_lo     <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error      <= 1'b0;
      acc        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= len_sat;
            idx      <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            error    <= 1'b0;
            acc      <= '0;
`endif
            if (len_sat != '0) begin
              state    <= RECV;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
            end else begin
              // Empty load completes immediately and releases the core.
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end

        RECV: begin
          if (xfer) begin
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              in_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= idx;
              imem_wdata <= full_word;
              byte_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              acc        <= acc ^ full_word;
`endif
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0:    asm_lo[7:0]   <= in_data;
                2'd1:    asm_lo[15:8]  <= in_data;
                default: asm_lo[23:16] <= in_data;
              endcase
            end
          end
        end

        WRITE: begin
          if (!last_word) begin
            idx      <= idx + ADDR_W'(1);
            state    <= RECV;
            in_ready <= 1'b1;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CHK;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum bytes reuse the word assembler; imem_wdata is left untouched.
        CHK: begin
          if (xfer) begin
            if (byte_cnt == 2'd3) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              byte_cnt <= '0;
              error    <= (full_word != acc);
              cpu_hold <= (full_word != acc);
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0:    asm_lo[7:0]   <= in_data;
                2'd1:    asm_lo[15:8]  <= in_data;
                default: asm_lo[23:16] <= in_data;
              endcase
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever imem_we is seen.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  tests    = 0;
  int  fails    = 0;
  int  we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  wr_t mon_e;
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
        check("write_data", imem_wdata, mon_e.data);
      end
    end
  end

  function automatic logic [31:0] pat(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b + 8'd1, ~b, 8'hA5, b};
  endfunction

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Starts at posedge+1; returns at 1 time unit after the edge that samples start.
  task automatic do_start(input int l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = (ADDR_W+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int n;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: byte 0x%02h not accepted, in_ready=%b", b, in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      send_byte(b, gap);
    end
  endtask

  task automatic finish_load(input logic [31:0] cks);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(cks, 1'b0);
`else
    if (cks === 32'hx) $display("unused checksum");
`endif
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] x;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_imem_wdata", imem_wdata,      32'd0);
    check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_write", 32'(we_count), 32'd0);
    check("post_rst_hold",     32'(cpu_hold), 32'd1);

    // Two-word back-to-back load
    base = we_count;
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00100593);
    do_start(2);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_busy",     32'(busy),     32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    fork
      begin
        repeat (9) @(posedge clk); #1;
        check("t1_done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("t1_done_at_10", 32'(done),     32'd1);
        check("t1_hold_at_10", 32'(cpu_hold), 32'd0);
        check("t1_busy_at_10", 32'(busy),     32'd0);
      end
      begin
        send_word(32'h00A00513, 1'b0);
        send_word(32'h00100593, 1'b0);
        in_valid = 1'b0;
      end
    join
`else
    send_word(32'h00A00513, 1'b0);
    send_word(32'h00100593, 1'b0);
    finish_load(32'h00B00080);
    in_valid = 1'b0;
`endif
    wait_done("t1_done");
    check("t1_write_count", 32'(we_count - base), 32'd2);

    // Bytes offered in DONE are ignored
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    check("done_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("done_no_write", 32'(we_count - base), 32'd2);

    // One word with gap cycles between bytes
    base = we_count;
    push_wr(0, 32'hDEADBEEF);
    do_start(1);
    check("t2_hold_reasserted", 32'(cpu_hold), 32'd1);
    send_word(32'hDEADBEEF, 1'b1);
    finish_load(32'hDEADBEEF);
    in_valid = 1'b0;
    wait_done("t2_done");
    check("t2_write_count", 32'(we_count - base), 32'd1);
    check("t2_hold",        32'(cpu_hold),        32'd0);
    repeat (3) @(negedge clk);
    check("t2_wdata_held",  imem_wdata,           32'hDEADBEEF);

    // Zero-length load
    base = we_count;
    do_start(0);
    check("t3_done", 32'(done),     32'd1);
    check("t3_busy", 32'(busy),     32'd0);
    check("t3_hold", 32'(cpu_hold), 32'd0);
    repeat (4) @(negedge clk);
    check("t3_no_write", 32'(we_count - base), 32'd0);

    // Asynchronous reset mid-word
    base = we_count;
    do_start(1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t4_busy",     32'(busy),      32'd0);
    check("t4_hold",     32'(cpu_hold),  32'd1);
    check("t4_in_ready", 32'(in_ready),  32'd0);
    check("t4_wdata",    imem_wdata,     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_no_write", 32'(we_count - base), 32'd0);
    check("t4_idle",     32'(busy),            32'd0);
    push_wr(0, 32'h11223344);
    do_start(1);
    send_word(32'h11223344, 1'b0);
    finish_load(32'h11223344);
    in_valid = 1'b0;
    wait_done("t4_fresh_done");
    check("t4_fresh_count", 32'(we_count - base), 32'd1);

    // start pulsed during RECV is ignored
    base = we_count;
    push_wr(0, 32'h04030201);
    push_wr(1, 32'h08070605);
    do_start(2);
    send_byte(8'h01, 1'b0);
    start = 1'b1;
    len   = '0;
    send_byte(8'h02, 1'b0);
    start = 1'b0;
    check("t5_busy_after_start", 32'(busy), 32'd1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_word(32'h08070605, 1'b0);
    finish_load(32'h04030201 ^ 32'h08070605);
    in_valid = 1'b0;
    wait_done("t5_done");
    check("t5_write_count", 32'(we_count - base), 32'd2);

    // len larger than DEPTH saturates
    base = we_count;
    x = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      push_wr(k, pat(k));
      x = x ^ pat(k);
    end
    do_start(int'(DEPTH) + 5);
    for (int k = 0; k < int'(DEPTH); k++) send_word(pat(k), 1'b0);
    finish_load(x);
    in_valid = 1'b0;
    wait_done("t6_done");
    check("t6_write_count", 32'(we_count - base), DEPTH);
    check("t6_last_addr",   32'(imem_addr),       DEPTH - 1);
    check("t6_last_wdata",  imem_wdata,           pat(int'(DEPTH) - 1));

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good, then bad, then cleared by a new start
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00100593);
    do_start(2);
    send_word(32'h00A00513, 1'b0);
    send_word(32'h00100593, 1'b0);
    send_word(32'h00B00080, 1'b0);
    in_valid = 1'b0;
    wait_done("t7_good_done");
    check("t7_good_error", 32'(error),    32'd0);
    check("t7_good_hold",  32'(cpu_hold), 32'd0);
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00100593);
    do_start(2);
    send_word(32'h00A00513, 1'b0);
    send_word(32'h00100593, 1'b0);
    send_word(32'h00000000, 1'b0);
    in_valid = 1'b0;
    wait_done("t7_bad_done");
    check("t7_bad_error", 32'(error),    32'd1);
    check("t7_bad_hold",  32'(cpu_hold), 32'd1);
    do_start(0);
    check("t7_error_cleared", 32'(error),    32'd0);
    check("t7_hold_released", 32'(cpu_hold), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 6: word-address width, with DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-006 SHALL have port len  input  ADDR_W+1  words to load, sampled in the cycle start is accepted.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port in_data  input  8  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready.
REQ-010 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  ADDR_W  word address of the write.
REQ-012 SHALL have port imem_wdata  output  32  instruction word to write.
REQ-013 SHALL have port cpu_hold  output  1  active-high reset to the processor core; 1 while the core is held.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  load complete.
REQ-016 SHALL have port error  output  1  checksum mismatch; constant 0 when IMEM_LOADER_CHECKSUM_EN is undefined.

Function
REQ-017 SHALL implement the FSM states IDLE, RECV, WRITE, CHK and DONE.
REQ-018 SHALL go from IDLE or DONE on start: to RECV if the latched len is nonzero, otherwise to DONE with no write.
REQ-019 SHALL saturate a latched len greater than DEPTH to DEPTH.
REQ-020 SHALL, in RECV, hold in_ready=1 and assemble bytes little-endian (first byte to bits 7:0, fourth byte to bits 31:24).
REQ-021 SHALL enter WRITE in the cycle after the fourth byte is accepted.
REQ-022 SHALL, in WRITE, hold in_ready=0 and assert imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word.
REQ-023 SHALL, after WRITE, go to RECV with index+1 if index < len-1; otherwise go to CHK when checksum is enabled, else to DONE.
REQ-024 SHALL give a throughput of one word per 5 cycles when in_valid is held high, and SHALL tolerate any number of in_valid=0 gap cycles without losing bytes.
REQ-025 SHALL keep imem_addr and imem_wdata stable outside WRITE; they hold their last written values.
REQ-026 SHALL assert busy=1 in RECV, WRITE and CHK, and 0 otherwise.
REQ-027 SHALL assert done=1 only in DONE.
REQ-028 SHALL drive cpu_hold=1 from reset until DONE is entered with no error, and SHALL reassert it in the cycle a new start is accepted.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL keep in_ready=0 in IDLE, WRITE and DONE; bytes offered there are neither consumed nor stored.

Reset
REQ-031 SHALL, on reset=0 and regardless of clk, force state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, word index 0, byte count 0.
REQ-032 SHALL discard any partially assembled word on reset mid-load; no write is issued for it.
REQ-033 SHALL issue no write in the cycle reset deasserts; the first write requires a new start.

Configuration
REQ-034 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, accumulate the XOR of all written words, cleared on start.
REQ-035 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, receive 4 further bytes little-endian in CHK, then enter DONE with error = (received != accumulated).
REQ-036 SHALL, with IMEM_LOADER_CHECKSUM_EN defined and error=1, keep cpu_hold=1 in DONE.
REQ-037 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, clear error on the next accepted start.
REQ-038 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit CHK and the accumulator and tie error to 0.

Verification
REQ-039 SHALL cover: len=2, bytes 13 05 A0 00 93 05 10 00 streamed back-to-back -> writes (0,0x00A00513) then (1,0x00100593), done=1 and cpu_hold=0 ten cycles after start.
REQ-040 SHALL cover: len=1 with in_valid low every other cycle -> exactly one write of the assembled word, no dropped bytes.
REQ-041 SHALL cover: len=0 -> DONE next cycle, zero imem_we pulses, cpu_hold=0.
REQ-042 SHALL cover: reset pulled low after 2 of 4 bytes -> IDLE, cpu_hold=1, no write, and a fresh load afterward writes address 0.
REQ-043 SHALL cover: checksum enabled, len=2, words 0x00A00513 and 0x00100593 followed by checksum 0x00B00080 -> error=0; checksum 0x00000000 -> error=1 and cpu_hold stays 1.
REQ-044 SHALL cover: start pulsed during RECV -> ignored, and len=DEPTH+5 -> exactly DEPTH writes.
